// File: rtl/nn_pkg.sv
// Shared definitions for the fully-connected layer blocks: FSM states,
// activation selectors and the saturating clip helper.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    FIN  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic ACT_RELU   = 1'b0;
  localparam logic ACT_LINEAR = 1'b1;

  localparam int CLIP_W = 64;

  // Clip a wide signed value into the signed range of a dw-bit result.
  function automatic logic signed [CLIP_W-1:0] sat_clip(
    input logic signed [CLIP_W-1:0] v,
    input int                       dw
  );
    logic signed [CLIP_W-1:0] hi;
    logic signed [CLIP_W-1:0] lo;
    logic signed [CLIP_W-1:0] r;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi)      r = hi;
    else if (v < lo) r = lo;
    else             r = v;
    return r;
  endfunction

endpackage

// File: rtl/neuron_mac_serial_if.sv
// Bundle of the input-vector, result and weight-write ports of one neuron.
interface neuron_mac_serial_if #(
  parameter int N_IN = 10,
  parameter int DW   = 16
);
  localparam int AW = $clog2(N_IN + 1);

  // Both streams: a transfer happens on a rising edge where valid && ready;
  // the producer holds valid and its payload stable until that edge.
  logic                 in_valid;
  logic                 in_ready;
  logic [N_IN*DW-1:0]   in_data;
  logic                 act_mode;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;
  logic                 wr_err;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic                 out_sat;

  modport master (
    output in_valid, in_data, act_mode, wr_en, wr_addr, wr_data, out_ready,
    input  in_ready, wr_err, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, act_mode, wr_en, wr_addr, wr_data, out_ready,
    output in_ready, wr_err, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/nn_sat_act.sv
// Combinational post-processing of an accumulator: fixed-point shift,
// saturation to DW bits and ReLU/linear activation.
module nn_sat_act
  import nn_pkg::*;
#(
  parameter int DW    = 16,
  parameter int FRAC  = 0,
  parameter int ACC_W = 36
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic                    mode,
  output logic [DW-1:0]           data,
  output logic                    sat
);
  logic signed [ACC_W-1:0]  shifted;
  logic signed [CLIP_W-1:0] wide;
  logic signed [CLIP_W-1:0] clipped;

  always_comb begin
    shifted = acc >>> FRAC;
    wide    = CLIP_W'(shifted);
    clipped = sat_clip(wide, DW);
    sat     = (clipped != wide);
    // ReLU zeroes negatives after clipping; the clip flag is kept as is.
    if (mode == ACT_RELU && clipped[CLIP_W-1]) data = '0;
    else                                       data = clipped[DW-1:0];
  end
endmodule

// File: rtl/neuron_mac_serial.sv
// Time-multiplexed neuron: one shared multiplier walks the N_IN inputs,
// then a shift/saturate/activate stage produces the registered result.
module neuron_mac_serial
  import nn_pkg::*;
#(
  parameter int N_IN = 10,
  parameter int DW   = 16,
  parameter int FRAC = 0,
  localparam int ACC_W = 2*DW + $clog2(N_IN + 1)
) (
  input  logic                clk,
  input  logic                reset,
  neuron_mac_serial_if.slave  bus,
  output state_t              state
);
  localparam int AW = $clog2(N_IN + 1);
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

  state_t                   next_state;
  logic signed [DW-1:0]     w [N_IN];
  logic signed [DW-1:0]     bias;
  logic signed [DW-1:0]     bias_eff;
  logic signed [DW-1:0]     x_q [N_IN];
  logic                     mode_q;
  logic [IW-1:0]            idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [2*DW-1:0]   prod;
  logic                     accept;
  logic                     wr_ok;
  logic                     last;
  logic [DW-1:0]            fin_data;
  logic                     fin_sat;

  assign accept = bus.in_valid && (state == IDLE);
  assign wr_ok  = bus.wr_en && (state == IDLE) && (bus.wr_addr <= AW'(N_IN));
  assign last   = (idx == IW'(N_IN - 1));
  assign prod   = x_q[idx] * w[idx];
  // A bias write on the accepting edge must already seed this sample.
  assign bias_eff = (wr_ok && bus.wr_addr == AW'(N_IN)) ? $signed(bus.wr_data) : bias;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) w[i] <= '0;
      bias       <= '0;
      bus.wr_err <= 1'b0;
    end else begin
      bus.wr_err <= bus.wr_en && !wr_ok;
      if (wr_ok) begin
        if (bus.wr_addr == AW'(N_IN)) bias <= $signed(bus.wr_data);
        else                          w[bus.wr_addr] <= $signed(bus.wr_data);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.in_valid) next_state = MAC;
      MAC:     if (last) next_state = FIN;
      FIN:     next_state = OUT;
      OUT:     if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == OUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) x_q[i] <= '0;
      mode_q       <= ACT_RELU;
      idx          <= '0;
      acc          <= '0;
      bus.out_data <= '0;
      bus.out_sat  <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < N_IN; i++) x_q[i] <= $signed(bus.in_data[i*DW +: DW]);
        mode_q <= bus.act_mode;
        acc    <= ACC_W'(bias_eff) <<< FRAC;
        idx    <= '0;
      end
      if (state == MAC) begin
        acc <= acc + ACC_W'(prod);
        idx <= idx + 1'b1;
      end
      if (state == FIN) begin
        bus.out_data <= fin_data;
        bus.out_sat  <= fin_sat;
      end
    end
  end

  nn_sat_act #(.DW(DW), .FRAC(FRAC), .ACC_W(ACC_W)) u_sat_act (
    .acc  (acc),
    .mode (mode_q),
    .data (fin_data),
    .sat  (fin_sat)
  );
endmodule

// File: tb/tb_neuron_mac_serial.sv
// Randomised and directed bench for neuron_mac_serial against an integer
// dot-product reference model.
module tb_neuron_mac_serial;
  import nn_pkg::*;

  localparam int N  = 10;
  localparam int DW = 16;

  logic   clk;
  logic   reset;
  state_t dut_state;
  int     cyc;
  int     acc_cyc;
  int     n_checks;
  int     n_errors;
  int     mw [N];
  int     mb;
  logic [DW-1:0] last_data;
  logic [DW:0]   exp_q[$];

  neuron_mac_serial_if #(.N_IN(N), .DW(DW)) bus ();

  neuron_mac_serial #(.N_IN(N), .DW(DW), .FRAC(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (dut_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer dot product plus bias, clip, then activation.
  function automatic logic [DW:0] model(input logic [N*DW-1:0] xv, input logic mode);
    longint s;
    logic   sat;
    s = longint'(mb);
    for (int i = 0; i < N; i++)
      s += longint'($signed(xv[i*DW +: DW])) * longint'(mw[i]);
    sat = 1'b0;
    if (s > 32767)       begin s = 32767;  sat = 1'b1; end
    else if (s < -32768) begin s = -32768; sat = 1'b1; end
    if (mode == ACT_RELU && s < 0) s = 0;
    return {sat, 16'(s)};
  endfunction

  function automatic logic [N*DW-1:0] fill(input int v);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = 16'(v);
    return r;
  endfunction

  // driver tasks
  task automatic write_reg(input int addr, input int data, input bit exp_err);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(addr);
    bus.wr_data = 16'(data);
    tick();
    bus.wr_en = 1'b0;
    check("wr_err_pulse", 64'(bus.wr_err), 64'(exp_err));
    if (!exp_err) begin
      if (addr == N) mb = data;
      else           mw[addr] = data;
    end else begin
      tick();
      check("wr_err_clear", 64'(bus.wr_err), 64'd0);
    end
  endtask

  task automatic load_weights(input int ws [N], input int b);
    for (int i = 0; i < N; i++) write_reg(i, ws[i], 1'b0);
    write_reg(N, b, 1'b0);
  endtask

  task automatic start_sample(input logic [N*DW-1:0] xv, input logic mode, input int stall,
                              input bit do_wr, input int wr_a, input int wr_d);
    int t;
    t = 0;
    while (!bus.in_ready && t < 40) begin tick(); t++; end
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.out_ready = (stall == 0);
    bus.in_valid  = 1'b1;
    bus.in_data   = xv;
    bus.act_mode  = mode;
    if (do_wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'(wr_a);
      bus.wr_data = 16'(wr_d);
      if (wr_a == N) mb = wr_d;
      else           mw[wr_a] = wr_d;
    end
    exp_q.push_back(model(xv, mode));
    tick();
    bus.in_valid = 1'b0;
    bus.wr_en    = 1'b0;
    acc_cyc      = cyc;
    if (do_wr) check("wr_err_on_accept", 64'(bus.wr_err), 64'd0);
  endtask

  // scoreboard: compare the result against the oldest expected entry
  task automatic wait_result(input int stall);
    int         t;
    logic [DW:0] e;
    t = 0;
    while (!bus.out_valid && t < 60) begin tick(); t++; end
    check("latency", 64'(cyc - acc_cyc), 64'd11);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("out_data", 64'(bus.out_data), 64'(e[DW-1:0]));
    check("out_sat", 64'(bus.out_sat), 64'(e[DW]));
    last_data = bus.out_data;
    for (int k = 0; k < stall; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {5{$urandom()}};
      tick();
      check("hold_data", 64'(bus.out_data), 64'(e[DW-1:0]));
      check("hold_sat", 64'(bus.out_sat), 64'(e[DW]));
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("hold_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("release_valid", 64'(bus.out_valid), 64'd0);
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run(input logic [N*DW-1:0] xv, input logic mode, input int stall);
    start_sample(xv, mode, stall, 1'b0, 0, 0);
    wait_result(stall);
  endtask

  initial begin
    int              w1 [N];
    int              wmax [N];
    logic [N*DW-1:0] xv;
    int              seen;

    w1   = '{-60, -55, 7, 31, -4, 33, -34, -20, 44, -4};
    wmax = '{default: 32767};
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    mb       = 0;
    for (int i = 0; i < N; i++) mw[i] = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.act_mode  = ACT_RELU;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_sat", 64'(bus.out_sat), 64'd0);
    check("rst_wr_err", 64'(bus.wr_err), 64'd0);
    check("rst_state", 64'(dut_state), 64'(IDLE));

    // basic dot product, linear and ReLU
    load_weights(w1, 5);
    run(fill(1), ACT_LINEAR, 0);
    check("t1_linear_lit", 64'(last_data), 64'hFFC7);
    run(fill(1), ACT_RELU, 0);
    xv = '0;
    xv[DW-1:0] = 16'hFFFF;
    run(xv, ACT_RELU, 0);
    check("t2_relu_lit", 64'(last_data), 64'd65);

    // saturation at both ends
    load_weights(wmax, 0);
    run(fill(32767), ACT_LINEAR, 0);
    check("t3_pos_lit", 64'(last_data), 64'h7FFF);
    run(fill(-32768), ACT_LINEAR, 0);
    check("t3_neg_lit", 64'(last_data), 64'h8000);
    run(fill(-32768), ACT_RELU, 0);

    // backpressure with a competing in_valid
    run(fill(3), ACT_LINEAR, 5);
    tick();
    check("t4_not_accepted", 64'(dut_state), 64'(IDLE));

    // dropped writes: during MAC and with an out-of-range address
    load_weights(w1, 5);
    start_sample(fill(1), ACT_LINEAR, 0, 1'b0, 0, 0);
    tick();
    write_reg(0, 999, 1'b1);
    wait_result(0);
    write_reg(11, 1234, 1'b1);
    run(fill(1), ACT_LINEAR, 0);
    check("t5_rerun_lit", 64'(last_data), 64'hFFC7);

    // reset during the 4th MAC cycle
    start_sample(fill(1), ACT_LINEAR, 0, 1'b0, 0, 0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    mb = 0;
    for (int i = 0; i < N; i++) mw[i] = 0;
    check("t6_in_ready", 64'(bus.in_ready), 64'd1);
    check("t6_out_valid", 64'(bus.out_valid), 64'd0);
    check("t6_state", 64'(dut_state), 64'(IDLE));
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("t6_no_partial", 64'(seen), 64'd0);
    run(fill(1), ACT_LINEAR, 0);
    check("t6_zero_lit", 64'(last_data), 64'd0);

    // bias write on the accepting edge is used by that sample
    start_sample(fill(1), ACT_LINEAR, 0, 1'b1, N, 100);
    wait_result(0);

    // randomised samples with weight updates and backpressure
    for (int it = 0; it < 30; it++) begin
      write_reg($urandom_range(0, N), int'($urandom_range(0, 65535)) - 32768, 1'b0);
      write_reg($urandom_range(0, N - 1), int'($urandom_range(0, 511)) - 256, 1'b0);
      if ($urandom_range(0, 4) == 0) write_reg($urandom_range(N + 1, 15), 7, 1'b1);
      run({5{$urandom()}}, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
